// File: rtl/data_counter_bank.sv
// Bank of up/down counters that share one set of panel buttons. Supports unsigned,
// sign-magnitude and two's-complement encodings, a runtime step, saturate/wrap and auto-repeat.
module data_counter_bank #(
  parameter int    Size        = 5,
  parameter int    Channels    = 4,
  parameter string Mode        = "Unsigned",
  parameter string Wrap        = "No",
  parameter int    StepWidth   = 3,
  parameter int    RepeatDelay = 8,
  parameter int    RepeatRate  = 4,
  localparam int   SelWidth    = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [SelWidth-1:0]      Sel,
  input  logic                     Up,
  input  logic                     Down,
  input  logic                     Sign,
  input  logic                     Load,
  input  logic [Size-1:0]          LoadValue,
  input  logic [StepWidth-1:0]     Step,
  output logic [Size-1:0]          Data,
  output logic                     SignBit,
  output logic                     AtMax,
  output logic                     AtMin,
  output logic [Channels*Size-1:0] AllData
);

  localparam bit IsSignMag  = (Mode == "SignMag");
  localparam bit IsTwos     = (Mode == "TwosComp");
  localparam bit IsUnsigned = !IsSignMag && !IsTwos;
  localparam bit DoWrap     = (Wrap == "Yes") && !IsSignMag;
  localparam int W          = Size + StepWidth + 1;
  localparam int MaxRep     = (RepeatDelay > RepeatRate) ? RepeatDelay : RepeatRate;
  localparam int CntWidth   = $clog2(MaxRep + 1);

  localparam logic signed [W-1:0] MaxVal = IsUnsigned ? W'((2**Size) - 1) : W'((2**(Size-1)) - 1);
  localparam logic signed [W-1:0] MinVal = IsUnsigned ? '0 :
                                           (IsSignMag ? W'(-((2**(Size-1)) - 1)) : W'(-(2**(Size-1))));

  // 1 followed by zeros: two's-complement minimum, and the sign-magnitude "-0" pattern.
  localparam logic [Size-1:0] TopBit  = {1'b1, {(Size-1){1'b0}}};
  localparam logic [Size-1:0] MaxCode = IsUnsigned ? '1 : ~TopBit;
  localparam logic [Size-1:0] MinCode = IsUnsigned ? '0 : (IsSignMag ? '1 : TopBit);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  function automatic logic signed [W-1:0] decode(input logic [Size-1:0] raw);
    logic signed [W-1:0] mag;
    mag = signed'(W'(raw[Size-2:0]));
    if (IsSignMag) return raw[Size-1] ? -mag : mag;
    if (IsTwos) return W'(signed'(raw));
    return signed'(W'(raw));
  endfunction

  function automatic logic [Size-1:0] encode(input logic signed [W-1:0] v);
    logic signed [W-1:0] mag;
    mag = (v < 0) ? -v : v;
    if (IsSignMag) return {v[W-1], mag[Size-2:0]};
    return v[Size-1:0];
  endfunction

  function automatic logic [Size-1:0] apply_step(input logic [Size-1:0] raw,
                                                 input logic down,
                                                 input logic [StepWidth-1:0] step);
    logic signed [W-1:0] v;
    logic signed [W-1:0] s;
    logic signed [W-1:0] r;
    v = decode(raw);
    s = signed'(W'(step));
    r = down ? v - s : v + s;
    if (!DoWrap) begin
      if (r > MaxVal) r = MaxVal;
      else if (r < MinVal) r = MinVal;
    end
    return encode(r);
  endfunction

  function automatic logic [Size-1:0] negate(input logic [Size-1:0] raw);
    if (IsSignMag) return (raw[Size-2:0] == '0) ? raw : {~raw[Size-1], raw[Size-2:0]};
    if (IsTwos) return (raw == TopBit) ? ~TopBit : -raw;
    return raw;
  endfunction

  state_t              state_reg, state_next;
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic                dir_reg, dir_next;
  logic [SelWidth-1:0] sel_reg, sel_next;
  logic                up_armed_reg, down_armed_reg, sign_armed_reg;
  logic [Size-1:0]     count_reg [Channels];
  logic [Size-1:0]     count_next [Channels];

  logic                up_edge, down_edge, sign_act, fire;
  logic                active_btn, other_btn;
  logic [CntWidth-1:0] limit;
  logic [Size-1:0]     load_norm;
  logic [Size-1:0]     data_sel;
  logic                sel_hit;

  // Armed registers remember "button was low last cycle"; they clear on reset so a
  // button held through reset needs a fresh press.
  assign up_edge    = Up & up_armed_reg;
  assign down_edge  = Down & down_armed_reg;
  assign sign_act   = Sign & sign_armed_reg & !IsUnsigned;
  assign active_btn = dir_reg ? Down : Up;
  assign other_btn  = dir_reg ? Up : Down;
  assign limit      = (state_reg == DELAY) ? CntWidth'(RepeatDelay - 1) : CntWidth'(RepeatRate - 1);
  assign load_norm  = (IsSignMag && LoadValue == TopBit) ? '0 : LoadValue;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    sel_next   = sel_reg;
    fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (up_edge || (down_edge && !Up)) begin
          fire       = 1'b1;
          dir_next   = !up_edge;
          sel_next   = Sel;
          cnt_next   = '0;
          state_next = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!active_btn || other_btn || Sel != sel_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == limit) begin
          fire       = 1'b1;
          cnt_next   = '0;
          state_next = REPEAT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (Load) state_next = IDLE;
  end

  generate
    for (genvar gi = 0; gi < Channels; gi++) begin : g_chan
      logic hit;
      assign hit = (Sel == SelWidth'(gi));
      assign count_next[gi] = !hit     ? count_reg[gi] :
                              Load     ? load_norm :
                              sign_act ? negate(count_reg[gi]) :
                              fire     ? apply_step(count_reg[gi], dir_next, Step) :
                                         count_reg[gi];
      assign AllData[gi*Size +: Size] = count_reg[gi];
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      dir_reg        <= 1'b0;
      sel_reg        <= '0;
      up_armed_reg   <= 1'b0;
      down_armed_reg <= 1'b0;
      sign_armed_reg <= 1'b0;
      count_reg      <= '{default: '0};
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dir_reg        <= dir_next;
      sel_reg        <= sel_next;
      up_armed_reg   <= ~Up;
      down_armed_reg <= ~Down;
      sign_armed_reg <= ~Sign;
      count_reg      <= count_next;
    end
  end

  // Out-of-range selects read as zero with both bound flags low.
  always_comb begin
    data_sel = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < Channels; i++) begin
      if (Sel == SelWidth'(i)) begin
        data_sel = count_reg[i];
        sel_hit  = 1'b1;
      end
    end
  end

  assign Data    = data_sel;
  assign SignBit = !IsUnsigned && data_sel[Size-1];
  assign AtMax   = sel_hit && (data_sel == MaxCode);
  assign AtMin   = sel_hit && (data_sel == MinCode);

endmodule
